// File: rtl/ps2_dir_pkg.sv
// Shared definitions for the PS/2 arrow-key direction decoder:
// scan-code constants, FSM state encoding, direction codes and
// small lookup helpers used by the decoder datapath.
package ps2_dir_pkg;

    // Prefix bytes
    localparam logic [7:0] SC_EXT   = 8'hE0;
    localparam logic [7:0] SC_BRK   = 8'hF0;

    // Extended (E0-prefixed) arrow make codes
    localparam logic [7:0] SC_UP    = 8'h75;
    localparam logic [7:0] SC_RIGHT = 8'h74;
    localparam logic [7:0] SC_DOWN  = 8'h72;
    localparam logic [7:0] SC_LEFT  = 8'h6B;

    // Non-extended WASD make codes
    localparam logic [7:0] SC_W     = 8'h1D;
    localparam logic [7:0] SC_D     = 8'h23;
    localparam logic [7:0] SC_S     = 8'h1B;
    localparam logic [7:0] SC_A     = 8'h1C;

    // Resolved direction codes
    localparam logic [2:0] DIR_NONE  = 3'd0;
    localparam logic [2:0] DIR_UP    = 3'd1;
    localparam logic [2:0] DIR_RIGHT = 3'd2;
    localparam logic [2:0] DIR_DOWN  = 3'd3;
    localparam logic [2:0] DIR_LEFT  = 3'd4;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_EXT,
        ST_BRK,
        ST_EXT_BRK
    } state_t;

    // Held-key vector: bit 0 up, bit 1 right, bit 2 down, bit 3 left
    typedef logic [3:0] held_t;

    // Direction named by an extended arrow code, DIR_NONE otherwise
    function automatic logic [2:0] arrow_dir(input logic [7:0] code);
        logic [2:0] dir;
        dir = DIR_NONE;
        case (code)
            SC_UP:    dir = DIR_UP;
            SC_RIGHT: dir = DIR_RIGHT;
            SC_DOWN:  dir = DIR_DOWN;
            SC_LEFT:  dir = DIR_LEFT;
            default:  dir = DIR_NONE;
        endcase
        return dir;
    endfunction

    // Direction named by a WASD code, DIR_NONE otherwise
    function automatic logic [2:0] wasd_dir(input logic [7:0] code);
        logic [2:0] dir;
        dir = DIR_NONE;
        case (code)
            SC_W:    dir = DIR_UP;
            SC_D:    dir = DIR_RIGHT;
            SC_S:    dir = DIR_DOWN;
            SC_A:    dir = DIR_LEFT;
            default: dir = DIR_NONE;
        endcase
        return dir;
    endfunction

    // One-hot held-vector mask for a direction code (zero for DIR_NONE)
    function automatic held_t dir_mask(input logic [2:0] dir);
        held_t mask;
        mask = '0;
        case (dir)
            DIR_UP:    mask = 4'b0001;
            DIR_RIGHT: mask = 4'b0010;
            DIR_DOWN:  mask = 4'b0100;
            DIR_LEFT:  mask = 4'b1000;
            default:   mask = '0;
        endcase
        return mask;
    endfunction

    // Last-pressed key wins while held; otherwise up > right > down > left
    function automatic logic [2:0] resolve_dir(input held_t held, input logic [2:0] last);
        logic [2:0] dir;
        dir = DIR_NONE;
        if (held[3]) dir = DIR_LEFT;
        if (held[2]) dir = DIR_DOWN;
        if (held[1]) dir = DIR_RIGHT;
        if (held[0]) dir = DIR_UP;
        if ((held & dir_mask(last)) != '0) dir = last;
        return dir;
    endfunction

endpackage

// File: rtl/ps2_strobe_edge.sv
// Rising-edge detector for the PS/2 byte-valid strobe. A strobe that
// stays high for several cycles yields exactly one byte_accept pulse.
module ps2_strobe_edge (
    input  logic clock,
    input  logic reset,
    input  logic ps2_key_pressed,
    output logic byte_accept
);

    logic strobe_q;

    // Remember the strobe level from the previous cycle
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            strobe_q <= 1'b0;
        end else begin
            // NOTE: registered state uses non-blocking assignment so every flop samples pre-edge values.
            strobe_q <= ps2_key_pressed;
        end
    end

    assign byte_accept = ps2_key_pressed & ~strobe_q;

endmodule

// File: rtl/ps2_dir_decoder.sv
// PS/2 set-2 arrow-key decoder feeding the processor direction register.
// Tracks make/break state of the four arrows, drives the per-key level
// outputs and a registered, resolved 3-bit direction code.
// Optional: define PS2_DIR_WASD_EN to also accept W/A/S/D as arrows.
module ps2_dir_decoder
    import ps2_dir_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 1000000,
    parameter int CNT_W          = 20
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       ps2_key_pressed,
    input  logic [7:0] ps2_out,
    output logic       upSig,
    output logic       rightSig,
    output logic       downSig,
    output logic       leftSig,
    output logic [2:0] dir_code
);

    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic             byte_accept;
    state_t           state, state_n;
    held_t            held, held_n;
    logic [2:0]       last, last_n;
    logic [2:0]       dir_n;
    logic [CNT_W-1:0] cnt, cnt_n;

    logic [2:0]       arrow_d;
    held_t            arrow_m;

    assign arrow_d = arrow_dir(ps2_out);
    assign arrow_m = dir_mask(arrow_d);

`ifdef PS2_DIR_WASD_EN
    logic [2:0]       wasd_d;
    held_t            wasd_m;

    assign wasd_d = wasd_dir(ps2_out);
    assign wasd_m = dir_mask(wasd_d);
`endif

    ps2_strobe_edge u_strobe_edge (
        .clock           (clock),
        .reset           (reset),
        .ps2_key_pressed (ps2_key_pressed),
        .byte_accept     (byte_accept)
    );

    // Next-state decode: byte handling first, timeout only when no byte arrives
    always_comb begin
        // NOTE: every combinational output is defaulted up front so no path can infer a latch.
        state_n = state;
        held_n  = held;
        last_n  = last;
        cnt_n   = cnt;

        if (byte_accept) begin
            cnt_n = '0;
            case (state)
                ST_IDLE: begin
                    if (ps2_out == SC_EXT) begin
                        state_n = ST_EXT;
                    end else if (ps2_out == SC_BRK) begin
                        state_n = ST_BRK;
                    end
`ifdef PS2_DIR_WASD_EN
                    else if (wasd_d != DIR_NONE && (held & wasd_m) == '0) begin
                        held_n = held | wasd_m;
                        last_n = wasd_d;
                    end
`endif
                end
                ST_EXT: begin
                    if (ps2_out == SC_BRK) begin
                        state_n = ST_EXT_BRK;
                    end else begin
                        state_n = ST_IDLE;
                        // A repeat make of a held key leaves last-pressed alone
                        if (arrow_d != DIR_NONE && (held & arrow_m) == '0) begin
                            held_n = held | arrow_m;
                            last_n = arrow_d;
                        end
                    end
                end
                ST_EXT_BRK: begin
                    state_n = ST_IDLE;
                    held_n  = held & ~arrow_m;
                end
                ST_BRK: begin
                    state_n = ST_IDLE;
`ifdef PS2_DIR_WASD_EN
                    held_n  = held & ~wasd_m;
`endif
                end
                default: state_n = ST_IDLE;
            endcase
        end else if (state != ST_IDLE) begin
            if (cnt == TIMEOUT_LAST) begin
                state_n = ST_IDLE;
                cnt_n   = '0;
            end else begin
                cnt_n = cnt + 1'b1;
            end
        end else begin
            cnt_n = '0;
        end

        dir_n = resolve_dir(held_n, last_n);
    end

    // FSM, held bits, last-pressed key, timeout counter and direction register
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state    <= ST_IDLE;
            held     <= '0;
            last     <= DIR_NONE;
            cnt      <= '0;
            dir_code <= DIR_NONE;
        end else begin
            state    <= state_n;
            held     <= held_n;
            last     <= last_n;
            cnt      <= cnt_n;
            dir_code <= dir_n;
        end
    end

    assign upSig    = held[0];
    assign rightSig = held[1];
    assign downSig  = held[2];
    assign leftSig  = held[3];

endmodule

// File: tb/tb_ps2_dir_decoder.sv
// Self-checking bench for ps2_dir_decoder. Directed scenarios followed by
// random complete key sequences, all checked against a key-level model.
module tb_ps2_dir_decoder;

    localparam int TO = 16;

    logic       clock = 1'b0;
    logic       reset;
    logic       ps2_key_pressed;
    logic [7:0] ps2_out;
    logic       upSig, rightSig, downSig, leftSig;
    logic [2:0] dir_code;

    int total = 0;
    int bad   = 0;
    int acc_cnt = 0;

    // Key-level reference model
    bit m_held[4];
    int m_last;

    logic [7:0] arrow_code [4] = '{8'h75, 8'h74, 8'h72, 8'h6B};
    logic [7:0] wasd_code  [4] = '{8'h1D, 8'h23, 8'h1B, 8'h1C};

    ps2_dir_decoder #(.TIMEOUT_CYCLES(TO), .CNT_W(5)) dut (
        .clock           (clock),
        .reset           (reset),
        .ps2_key_pressed (ps2_key_pressed),
        .ps2_out         (ps2_out),
        .upSig           (upSig),
        .rightSig        (rightSig),
        .downSig         (downSig),
        .leftSig         (leftSig),
        .dir_code        (dir_code)
    );

    always #5 clock = ~clock;

    // Count accepted bytes mid-cycle, away from the clock edge
    always @(negedge clock) begin
        if (dut.u_strobe_edge.byte_accept === 1'b1) acc_cnt++;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic int arrow_idx(input logic [7:0] b);
        for (int i = 0; i < 4; i++) if (arrow_code[i] == b) return i;
        return -1;
    endfunction

    function automatic int wasd_idx(input logic [7:0] b);
        for (int i = 0; i < 4; i++) if (wasd_code[i] == b) return i;
        return -1;
    endfunction

    task automatic m_reset();
        for (int i = 0; i < 4; i++) m_held[i] = 1'b0;
        m_last = 0;
    endtask

    task automatic m_make(input int k);
        if (!m_held[k]) begin
            m_held[k] = 1'b1;
            m_last = k + 1;
        end
    endtask

    task automatic m_break(input int k);
        m_held[k] = 1'b0;
    endtask

    function automatic int m_dir();
        if (m_last != 0 && m_held[m_last-1]) return m_last;
        for (int i = 0; i < 4; i++) if (m_held[i]) return i + 1;
        return 0;
    endfunction

    function automatic logic [6:0] m_expect();
        int d;
        d = m_dir();
        return {m_held[0], m_held[1], m_held[2], m_held[3], d[2:0]};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Outputs packed as {up,right,down,left,dir_code[2:0]}
    task automatic check_outs(input string tag);
        check(tag, {25'd0, upSig, rightSig, downSig, leftSig, dir_code}, {25'd0, m_expect()});
    endtask

    // Strobe a byte for len cycles, then hold the strobe low for gap cycles
    task automatic send_byte_len(input logic [7:0] b, input int len, input int gap);
        ps2_out = b;
        ps2_key_pressed = 1'b1;
        repeat (len) @(posedge clock);
        #1;
        ps2_key_pressed = 1'b0;
        repeat (gap) @(posedge clock);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        send_byte_len(b, $urandom_range(1, 4), $urandom_range(1, 3));
    endtask

    task automatic make_arrow(input int k);
        send_byte(8'hE0);
        send_byte(arrow_code[k]);
        m_make(k);
    endtask

    task automatic break_arrow(input int k);
        send_byte(8'hE0);
        send_byte(8'hF0);
        send_byte(arrow_code[k]);
        m_break(k);
    endtask

    function automatic logic [7:0] rand_plain();
        logic [7:0] b;
        do b = 8'($urandom_range(0, 255));
        while (b == 8'hE0 || b == 8'hF0 || arrow_idx(b) >= 0);
        return b;
    endfunction

    initial begin
        int op, k;
        logic [7:0] b;

        // Reset state
        reset = 1'b1;
        ps2_key_pressed = 1'b0;
        ps2_out = 8'h00;
        m_reset();
        repeat (3) @(posedge clock);
        #1;
        check_outs("reset_state");
        reset = 1'b0;
        @(posedge clock);
        #1;
        acc_cnt = 0;

        // E0,75 with 3-cycle pulses; up visible exactly one cycle after accept
        send_byte_len(8'hE0, 3, 1);
        ps2_out = 8'h75;
        ps2_key_pressed = 1'b1;
        #1;
        check_outs("before_second_accept");
        @(posedge clock);
        #1;
        m_make(0);
        check_outs("up_after_accept");
        repeat (2) @(posedge clock);
        #1;
        ps2_key_pressed = 1'b0;
        @(posedge clock);
        #1;
        check("accept_count", acc_cnt, 2);

        // Right pressed last wins, release falls back to up
        make_arrow(1);
        check_outs("right_last_pressed");
        break_arrow(1);
        check_outs("right_released");

        // Typematic repeats leave state untouched, then release
        for (int i = 0; i < 5; i++) begin
            make_arrow(0);
            check_outs($sformatf("up_repeat_%0d", i));
        end
        break_arrow(0);
        check_outs("up_released");

        // Fallback priority when the last-pressed key goes away
        make_arrow(0);
        make_arrow(2);
        make_arrow(3);
        check_outs("left_last");
        break_arrow(3);
        check_outs("fallback_up");
        break_arrow(0);
        check_outs("fallback_down");
        break_arrow(2);
        check_outs("all_released");

        // Stray break of an unheld key
        break_arrow(1);
        check_outs("stray_break");

        // Timeout after a lone E0: a following 6B is ignored
        send_byte(8'hE0);
        repeat (TO + 4) @(posedge clock);
        #1;
        send_byte(8'h6B);
        check_outs("timeout_6b_ignored");

        // Byte landing on the timeout cycle wins
        send_byte_len(8'hE0, 1, 1);
        repeat (TO - 2) @(posedge clock);
        #1;
        send_byte_len(8'h75, 1, 1);
        m_make(0);
        check_outs("byte_beats_timeout");
        break_arrow(0);
        check_outs("boundary_release");

        // One cycle later the sequence has already been abandoned
        send_byte_len(8'hE0, 1, 1);
        repeat (TO - 1) @(posedge clock);
        #1;
        send_byte_len(8'h6B, 1, 1);
        check_outs("just_after_timeout");

        // Asynchronous reset mid-sequence
        make_arrow(3);
        check_outs("left_before_reset");
        send_byte(8'hE0);
        #2;
        reset = 1'b1;
        #1;
        m_reset();
        check_outs("async_reset");
        @(posedge clock);
        #1;
        reset = 1'b0;
        send_byte(8'h75);
        check_outs("fsm_reset_to_idle");
        make_arrow(2);
        check_outs("down_after_reset");
        break_arrow(2);

        // WASD left press/release
        send_byte(8'h1C);
`ifdef PS2_DIR_WASD_EN
        m_make(3);
`endif
        check_outs("wasd_a_make");
        send_byte(8'hF0);
        send_byte(8'h1C);
`ifdef PS2_DIR_WASD_EN
        m_break(3);
`endif
        check_outs("wasd_a_break");

        // Random complete sequences against the model
        for (int n = 0; n < 300; n++) begin
            op = $urandom_range(0, 6);
            k  = $urandom_range(0, 3);
            case (op)
                0, 1: make_arrow(k);
                2, 3: break_arrow(k);
                4: begin
                    b = rand_plain();
                    send_byte(8'hE0);
                    if ($urandom_range(0, 1) == 1) send_byte(8'hF0);
                    send_byte(b);
                end
                5: begin
                    b = 8'($urandom_range(0, 255));
                    if ($urandom_range(0, 1) == 1) b = wasd_code[k];
                    send_byte(8'hF0);
                    send_byte(b);
`ifdef PS2_DIR_WASD_EN
                    if (wasd_idx(b) >= 0) m_break(wasd_idx(b));
`endif
                end
                default: begin
                    b = rand_plain();
                    if ($urandom_range(0, 1) == 1) b = wasd_code[k];
                    send_byte(b);
`ifdef PS2_DIR_WASD_EN
                    if (wasd_idx(b) >= 0) m_make(wasd_idx(b));
`endif
                end
            endcase
            check_outs($sformatf("rand_%0d_op%0d", n, op));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
